// File: rtl/arith_pkg.sv
// Shared types and elaboration helpers for the sequential arithmetic blocks.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of digit slices needed to cover the full operand width.
    function automatic int unsigned calc_ndig(input int unsigned width, input int unsigned digit);
        return width / digit;
    endfunction

    // Counter width that can hold 0 .. ndig-1, never narrower than one bit.
    function automatic int unsigned calc_cnt_w(input int unsigned ndig);
        return (ndig <= 2) ? 1 : $clog2(ndig);
    endfunction

endpackage

// File: rtl/serial_addsub_ripple_slice.sv
// DIGIT-bit combinational ripple of full-adder cells; one slice per clock.
module ripple_slice #(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             ci,
    output logic [DIGIT-1:0] s_d,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT:0] w_c;

    // Full-adder chain from bit 0 upward; w_c[i] is the carry into bit i.
    always_comb begin
        w_c    = '0;
        s_d    = '0;
        w_c[0] = ci;
        for (int i = 0; i < int'(DIGIT); i++) begin
            s_d[i]   = a_d[i] ^ b_d[i] ^ w_c[i];
            w_c[i+1] = (a_d[i] & b_d[i]) | (w_c[i] & (a_d[i] ^ b_d[i]));
        end
    end

    assign co    = w_c[DIGIT];
    assign c_msb = w_c[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: FSM, operand shift registers, carry and flags.
module serial_addsub
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NDIG  = calc_ndig(WIDTH, DIGIT);
    localparam int unsigned CNT_W = calc_cnt_w(NDIG);

    // Reject configurations the slice arithmetic cannot cover exactly.
    generate
        if (WIDTH < 2 || DIGIT == 0 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
            $error("serial_addsub: DIGIT must divide WIDTH exactly and WIDTH must be >= 2");
        end
    endgenerate

    state_e           r_state;
    state_e           w_next;
    logic             w_accept;
    logic             w_last;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_ovf;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic [DIGIT-1:0] w_s;
    logic             w_co;
    logic             w_c_msb;
    logic [WIDTH-1:0] w_sum_shift;

    ripple_slice #(
        .DIGIT(DIGIT)
    ) u_slice (
        .a_d  (r_a[DIGIT-1:0]),
        .b_d  (r_b[DIGIT-1:0]),
        .ci   (r_carry),
        .s_d  (w_s),
        .co   (w_co),
        .c_msb(w_c_msb)
    );

    // New result digit enters at the top so the LSB digit lands at bit 0 after NDIG steps.
    assign w_sum_shift = (r_sum >> DIGIT) | (WIDTH'(w_s) << (WIDTH - DIGIT));

    // Next-state logic; start is honoured only in IDLE and DONE.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_last   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = RUN;
                end
            end
            RUN: begin
                if (r_cnt == CNT_W'(NDIG - 1)) begin
                    w_last = 1'b1;
                    w_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = RUN;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State register with status outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == IDLE) || (w_next == DONE);
            r_busy  <= (w_next == RUN);
            r_done  <= (w_next == DONE);
        end
    end

    // Operand load on accept, then one digit per cycle through the slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= cin ^ sub;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_sum   <= w_sum_shift;
            r_carry <= w_co;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_ovf <= w_c_msb ^ w_co;
            end
        end
    end

    assign ready = r_ready;
    assign busy  = r_busy;
    assign done  = r_done;
    assign sum   = r_sum;
    assign cout  = r_carry;
    assign ovf   = r_ovf;

endmodule
